// File: rtl/bcd_display_feeder_pkg.sv
// Shared constants and helpers for the display feeder: digit geometry,
// saturation limit, FSM state encoding and leading-zero blanking.
package bcd_display_feeder_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_W      = NUM_DIGITS * DIGIT_W;

  // Largest value representable on four decimal digits
  localparam logic [13:0] BCD_MAX = 14'd9999;

  // FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  // Blank pattern that shows a lone "0" on the ones digit
  localparam logic [NUM_DIGITS-1:0] LES_ZERO = 4'b1110;

  // Digit-off mask for leading zeros; the ones digit is always shown
  function automatic logic [NUM_DIGITS-1:0] lz_blank(input logic [BCD_W-1:0] bcd);
    logic [NUM_DIGITS-1:0] les;
    les[3] = (bcd[15:12] == DIGIT_W'(0));
    les[2] = les[3] && (bcd[11:8] == DIGIT_W'(0));
    les[1] = les[2] && (bcd[7:4] == DIGIT_W'(0));
    les[0] = 1'b0;
    return les;
  endfunction

endpackage

// File: rtl/bcd_display_feeder_if.sv
// Request/result bundle between game logic (master) and the display feeder
// (slave).
//   bin_in/load/points_in : conversion request from game logic
//   busy/done/overflow    : conversion status
//   Hexs/Points/LES       : committed bundle consumed by the display driver
interface bcd_display_feeder_if #(
  parameter int unsigned BIN_W = 14
);

  logic [BIN_W-1:0] bin_in;
  logic             load;
  logic [3:0]       points_in;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [15:0]      Hexs;
  logic [3:0]       Points;
  logic [3:0]       LES;

  modport master (
    output bin_in, load, points_in,
    input  busy, done, overflow, Hexs, Points, LES
  );

  modport slave (
    input  bin_in, load, points_in,
    output busy, done, overflow, Hexs, Points, LES
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
//   digit_in    : current BCD digit
//   digit_adj_c : corrected digit (combinational)
module bcd_digit_adj
  import bcd_display_feeder_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_adj_c
);

  assign digit_adj_c = (digit_in >= DIGIT_W'(5)) ? digit_in + DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/bcd_display_feeder.sv
// Converts a binary score to 4-digit packed BCD with a one-bit-per-cycle
// double-dabble, saturating at 9999, and commits the Hexs/Points/LES bundle
// for the 7-segment driver in a single cycle so partial results never show.
//   clk : system clock
//   RST : asynchronous reset, active-high
//   bus : request in, status and committed display bundle out
module bcd_display_feeder
  import bcd_display_feeder_pkg::*;
#(
  parameter int unsigned BIN_W    = 14,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                 clk,
  input  logic                 RST,
  bcd_display_feeder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(BIN_W);

  logic [1:0]            state_q,  state_d;
  logic [BIN_W-1:0]      shift_q,  shift_d;
  logic [BCD_W-1:0]      bcd_q,    bcd_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [3:0]            pts_cap_q, pts_cap_d;
  logic                  sat_q,    sat_d;
  logic [BCD_W-1:0]      hexs_q,   hexs_d;
  logic [3:0]            points_q, points_d;
  logic [NUM_DIGITS-1:0] les_q,    les_d;
  logic                  ovf_q,    ovf_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;

  logic [BCD_W-1:0]      bcd_adj_c;

  // Per-digit +3 correction applied before each shift
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in    (bcd_q[i*DIGIT_W +: DIGIT_W]),
      .digit_adj_c (bcd_adj_c[i*DIGIT_W +: DIGIT_W])
    );
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    pts_cap_d = pts_cap_q;
    sat_d     = sat_q;
    hexs_d    = hexs_q;
    points_d  = points_q;
    les_d     = les_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          // Clamp here so the BCD digits can never overflow during CONV
          if (bus.bin_in > BIN_W'(BCD_MAX)) begin
            shift_d = BIN_W'(BCD_MAX);
            sat_d   = 1'b1;
          end else begin
            shift_d = bus.bin_in;
            sat_d   = 1'b0;
          end
          pts_cap_d = bus.points_in;
          bcd_d     = '0;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end

      CONV: begin
        {bcd_d, shift_d} = {bcd_adj_c, shift_q} << 1;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        hexs_d   = bcd_q;
        points_d = pts_cap_q;
        ovf_d    = sat_q;
        les_d    = BLANK_LZ ? lz_blank(bcd_q) : '0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      pts_cap_q <= '0;
      sat_q     <= 1'b0;
      hexs_q    <= '0;
      points_q  <= '0;
      les_q     <= LES_ZERO;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      pts_cap_q <= pts_cap_d;
      sat_q     <= sat_d;
      hexs_q    <= hexs_d;
      points_q  <= points_d;
      les_q     <= les_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.Hexs     = hexs_q;
  assign bus.Points   = points_q;
  assign bus.LES      = les_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Self-checking bench for bcd_display_feeder: directed cases plus random
// scores, checked against a decimal-arithmetic reference model.
module tb_bcd_display_feeder;

  localparam int unsigned BIN_W    = 14;
  localparam bit          BLANK_LZ = 1'b1;
  localparam int unsigned LAT      = BIN_W + 1;
  // Load is only sampled in IDLE, which is reached on the commit edge
  localparam int unsigned PERIOD   = LAT + 1;

  logic clk = 1'b0;
  logic RST = 1'b0;

  always #5 clk = ~clk;

  bcd_display_feeder_if #(.BIN_W(BIN_W)) bus ();

  bcd_display_feeder #(
    .BIN_W    (BIN_W),
    .BLANK_LZ (BLANK_LZ)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference: last committed display bundle
  logic [15:0] exp_hexs;
  logic [3:0]  exp_les;
  logic [3:0]  exp_pts;
  logic        exp_ovf;

  function automatic int sat_val(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = sat_val(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] ref_les(input int v);
    int s;
    s = sat_val(v);
    if (!BLANK_LZ) return 4'b0000;
    return {s < 1000, s < 100, s < 10, 1'b0};
  endfunction

  task automatic model_commit(input int v, input logic [3:0] p);
    exp_hexs = ref_bcd(v);
    exp_les  = ref_les(v);
    exp_pts  = p;
    exp_ovf  = (v > 9999);
  endtask

  task automatic model_reset();
    exp_hexs = 16'h0000;
    exp_les  = 4'b1110;
    exp_pts  = 4'b0000;
    exp_ovf  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bundle(input string tag);
    check({tag, "_hexs"},   32'(bus.Hexs),     32'(exp_hexs));
    check({tag, "_les"},    32'(bus.LES),      32'(exp_les));
    check({tag, "_points"}, 32'(bus.Points),   32'(exp_pts));
    check({tag, "_ovf"},    32'(bus.overflow), 32'(exp_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion; optionally re-pulses load with a different value
  // at CONV cycle poke_cycle, which must be ignored.
  task automatic convert(input int v, input logic [3:0] p, input int poke_cycle, input int poke_v);
    bus.bin_in    = BIN_W'(v);
    bus.points_in = p;
    bus.load      = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int c = 0; c < int'(LAT); c++) begin
      if (c == poke_cycle) begin
        bus.load      = 1'b1;
        bus.bin_in    = BIN_W'(poke_v);
        bus.points_in = 4'hF;
      end else begin
        bus.load = 1'b0;
      end
      check("conv_busy", 32'(bus.busy), 32'd1);
      check("conv_done_low", 32'(bus.done), 32'd0);
      check("conv_hold_hexs", 32'(bus.Hexs), 32'(exp_hexs));
      tick();
    end
    bus.load = 1'b0;
    model_commit(v, p);
    check("commit_done", 32'(bus.done), 32'd1);
    check("commit_busy", 32'(bus.busy), 32'd0);
    check_bundle("commit");
    tick();
    check("after_done_low", 32'(bus.done), 32'd0);
    check("after_busy_low", 32'(bus.busy), 32'd0);
    check_bundle("after");
  endtask

  initial begin
    int v;
    logic [3:0] p;

    bus.bin_in    = '0;
    bus.load      = 1'b0;
    bus.points_in = 4'b0000;
    model_reset();

    // Async reset takes effect without a clock edge
    #1 RST = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_bundle("rst");
    tick();
    tick();
    RST = 1'b0;
    tick();

    convert(1234, 4'b0100, -1, 0);
    convert(7,    4'b0000, -1, 0);
    convert(0,    4'b0000, -1, 0);
    convert(305,  4'b0010, -1, 0);

    // Saturation boundaries
    convert(9999,  4'b0000, -1, 0);
    convert(12000, 4'b1000, -1, 0);
    convert(42,    4'b0000, -1, 0);
    convert(16383, 4'b0001, -1, 0);
    convert(10000, 4'b0000, -1, 0);

    // Load while busy is ignored
    convert(1111, 4'b0011, 5, 2222);

    // Load held high: back-to-back conversions, one pulse per period
    bus.load      = 1'b1;
    bus.bin_in    = BIN_W'(50);
    bus.points_in = 4'b0001;
    for (int k = 1; k <= 3 * int'(PERIOD); k++) begin
      tick();
      if (k % int'(PERIOD) == 0) begin
        model_commit(50, 4'b0001);
        check("held_done", 32'(bus.done), 32'd1);
        check_bundle("held");
      end else begin
        check("held_no_done", 32'(bus.done), 32'd0);
        check("held_busy", 32'(bus.busy), 32'd1);
      end
    end
    bus.load = 1'b0;
    tick();
    check("held_end_done", 32'(bus.done), 32'd0);
    check("held_end_busy", 32'(bus.busy), 32'd0);

    // Reset mid-conversion aborts without a done pulse
    convert(1234, 4'b0100, -1, 0);
    bus.bin_in    = BIN_W'(8888);
    bus.points_in = 4'b1111;
    bus.load      = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    RST = 1'b1;
    #1;
    model_reset();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check_bundle("abort");
    tick();
    RST = 1'b0;
    for (int c = 0; c < int'(PERIOD); c++) begin
      tick();
      check("post_abort_no_done", 32'(bus.done), 32'd0);
      check("post_abort_idle", 32'(bus.busy), 32'd0);
    end
    check_bundle("post_abort");
    convert(8888, 4'b0000, -1, 0);

    // Random scores, some with an ignored mid-conversion load
    for (int n = 0; n < 24; n++) begin
      v = int'($urandom_range(0, 16383));
      p = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        convert(v, p, int'($urandom_range(0, LAT - 1)), int'($urandom_range(0, 16383)));
      else
        convert(v, p, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
